// File: rtl/opcodes_pkg.sv
// -----------------------------------------------------------------------------
// opcodes_pkg
// Shared definitions for the stacked control unit: the instruction opcode
// encoding, the sequencer state encoding, and a helper that identifies the
// control-flow opcodes which present NOP to the datapath.
// -----------------------------------------------------------------------------
package opcodes_pkg;

   localparam int OPC_W = 4;

   // NOP/STA/JMP/JMPZ/JMPNZ and the ALU ops keep the first-generation
   // encodings; CALL, RET and HALT occupy previously unused codes.
   typedef enum logic [OPC_W-1:0] {
      NOP   = 4'h0,
      LDA   = 4'h1,
      STA   = 4'h2,
      ADD   = 4'h3,
      SUB   = 4'h4,
      LAND  = 4'h5,
      LOR   = 4'h6,
      LXOR  = 4'h7,
      JMP   = 4'h8,
      JMPZ  = 4'h9,
      JMPNZ = 4'hA,
      CALL  = 4'hB,
      RET   = 4'hC,
      HALT  = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALTED  = 2'd2
   } state_t;

   // CALL, RET and HALT are sequencer-only and must not reach the datapath.
   function automatic logic is_control_op(input opcode_t op);
      return (op == CALL) || (op == RET) || (op == HALT);
   endfunction

endpackage

// File: rtl/return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// LIFO of DEPTH entries of WIDTH bits holding return addresses.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset to empty
//   push   - write din on top (ignored when full)
//   pop    - discard top entry (ignored when empty)
//   din    - value to push
//   dout   - current top entry (zero when empty)
//   full   - DEPTH entries held
//   empty  - no entries held
// -----------------------------------------------------------------------------
module return_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] entry_r [DEPTH];
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] top_idx_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == CNT_W'(0));
   assign top_idx_s = count_r - CNT_W'(1);

   // Top-of-stack read; the index is only meaningful when non-empty.
   always_comb begin
      dout = {WIDTH{1'b0}};
      if (!empty) begin
         dout = entry_r[IDX_W'(top_idx_s)];
      end else begin
         dout = {WIDTH{1'b0}};
      end
   end

   // Entry storage and occupancy count; push has priority, guards stop over/underflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_r <= CNT_W'(0);
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push && !full) begin
         entry_r[IDX_W'(count_r)] <= din;
         count_r                  <= count_r + CNT_W'(1);
      end else if (pop && !empty) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/control_stacked.sv
// -----------------------------------------------------------------------------
// control_stacked
// Two-phase fetch/execute control unit with PC, IR, hardware return-address
// stack for CALL/RET, a HALT state and memory wait states.
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous active-high reset
//   data         - instruction/data read bus
//   mem_ready    - memory completes the current access this cycle
//   zflag        - datapath zero flag (sampled on the advancing edge)
//   address      - memory address (PC in FETCH/HALTED, operand in EXECUTE)
//   operation    - opcode presented to the datapath
//   memory_write - write strobe, high through the whole STA execute
//   halted       - unit stopped
//   stack_fault  - sticky CALL overflow / RET underflow indication
// All outputs are registered: they are computed from the next-state values
// so they line up with the state they describe.
// -----------------------------------------------------------------------------
module control_stacked
   import opcodes_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int OP_W        = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   input  logic              mem_ready,
   input  logic              zflag,
   output logic [ADDR_W-1:0] address,
   output logic [OP_W-1:0]   operation,
   output logic              memory_write,
   output logic              halted,
   output logic              stack_fault
);

   if (DATA_W - OP_W < ADDR_W) begin : g_bad_width
      $fatal(1, "control_stacked: DATA_W-OP_W must be >= ADDR_W");
   end
   if (OP_W != OPC_W) begin : g_bad_opw
      $fatal(1, "control_stacked: OP_W must match the opcode encoding width");
   end
   if (STACK_DEPTH < 1) begin : g_bad_depth
      $fatal(1, "control_stacked: STACK_DEPTH must be >= 1");
   end

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic [DATA_W-1:0] ir_r, ir_s;
   logic              fault_s;
   logic              push_s, pop_s;
   logic [ADDR_W-1:0] stack_top_s;
   logic              stack_full_s, stack_empty_s;
   opcode_t           opc_s, nxt_opc_s;
   logic [ADDR_W-1:0] operand_s;
   logic [ADDR_W-1:0] addr_s;
   logic [OP_W-1:0]   op_s;
   logic              wr_s, halt_s;

   assign opc_s     = opcode_t'(ir_r[DATA_W-1 -: OP_W]);
   assign nxt_opc_s = opcode_t'(ir_s[DATA_W-1 -: OP_W]);
   assign operand_s = ir_r[ADDR_W-1:0];

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_W)
   ) u_stack (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pc_r),
      .dout  (stack_top_s),
      .full  (stack_full_s),
      .empty (stack_empty_s)
   );

   // Sequencer next-state, PC, IR, stack control and fault decision.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      ir_s    = ir_r;
      fault_s = stack_fault;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      case (state_r)
         FETCH: begin
            if (mem_ready) begin
               ir_s    = data;
               pc_s    = pc_r + ADDR_W'(1);
               state_s = EXECUTE;
            end else begin
               state_s = FETCH;
            end
         end
         EXECUTE: begin
            if (mem_ready) begin
               state_s = FETCH;
               case (opc_s)
                  JMP: pc_s = operand_s;
                  JMPZ: begin
                     if (zflag) pc_s = operand_s;
                     else       pc_s = pc_r;
                  end
                  JMPNZ: begin
                     if (!zflag) pc_s = operand_s;
                     else        pc_s = pc_r;
                  end
                  CALL: begin
                     // PC already points past the CALL, so it is the return address.
                     if (!stack_full_s) begin
                        push_s = 1'b1;
                        pc_s   = operand_s;
                     end else begin
                        fault_s = 1'b1;
                        state_s = HALTED;
                     end
                  end
                  RET: begin
                     if (!stack_empty_s) begin
                        pop_s = 1'b1;
                        pc_s  = stack_top_s;
                     end else begin
                        fault_s = 1'b1;
                        state_s = HALTED;
                     end
                  end
                  HALT:    state_s = HALTED;
                  default: pc_s = pc_r;
               endcase
            end else begin
               state_s = EXECUTE;
            end
         end
         HALTED:  state_s = HALTED;
         default: state_s = FETCH;
      endcase
   end

   // Output values for the state being entered, so registered outputs match it.
   always_comb begin
      addr_s = pc_s;
      op_s   = NOP;
      wr_s   = 1'b0;
      halt_s = 1'b0;
      case (state_s)
         FETCH: begin
            addr_s = pc_s;
         end
         EXECUTE: begin
            addr_s = ir_s[ADDR_W-1:0];
            if (is_control_op(nxt_opc_s)) op_s = NOP;
            else                          op_s = nxt_opc_s;
            wr_s = (nxt_opc_s == STA);
         end
         HALTED: begin
            addr_s = pc_s;
            halt_s = 1'b1;
         end
         default: begin
            addr_s = pc_s;
         end
      endcase
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= FETCH;
         pc_r         <= {ADDR_W{1'b0}};
         ir_r         <= {DATA_W{1'b0}};
         stack_fault  <= 1'b0;
         address      <= {ADDR_W{1'b0}};
         operation    <= NOP;
         memory_write <= 1'b0;
         halted       <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         ir_r         <= ir_s;
         stack_fault  <= fault_s;
         address      <= addr_s;
         operation    <= op_s;
         memory_write <= wr_s;
         halted       <= halt_s;
      end
   end

endmodule

// File: tb/tb_control_stacked.sv
// -----------------------------------------------------------------------------
// tb_control_stacked
// Directed test of control_stacked with a behavioural program memory driving
// the data bus from the current address.
// -----------------------------------------------------------------------------
module tb_control_stacked;
   import opcodes_pkg::*;

   logic        clock;
   logic        reset;
   logic [15:0] data;
   logic        mem_ready;
   logic        zflag;
   logic [11:0] address;
   logic [3:0]  operation;
   logic        memory_write;
   logic        halted;
   logic        stack_fault;

   logic [15:0] mem [0:4095];
   int          total;
   int          bad;

   control_stacked #(
      .ADDR_W(12), .DATA_W(16), .OP_W(4), .STACK_DEPTH(4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .data         (data),
      .mem_ready    (mem_ready),
      .zflag        (zflag),
      .address      (address),
      .operation    (operation),
      .memory_write (memory_write),
      .halted       (halted),
      .stack_fault  (stack_fault)
   );

   assign data = mem[address];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] a);
      return {op, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [11:0] a, input logic [3:0] op,
                       input logic wr, input logic h, input logic f);
      chk({tag, ".address"}, 32'(address), 32'(a));
      chk({tag, ".operation"}, 32'(operation), 32'(op));
      chk({tag, ".memory_write"}, 32'(memory_write), 32'(wr));
      chk({tag, ".halted"}, 32'(halted), 32'(h));
      chk({tag, ".stack_fault"}, 32'(stack_fault), 32'(f));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clock);
      reset     = 1'b1;
      mem_ready = 1'b1;
      zflag     = 1'b0;
      #1;
      outs({tag, ".reset"}, 12'h000, 4'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      mem_ready = 1'b1;
      zflag     = 1'b0;

      // Basic program: JMP, STA, HALT.
      clear_mem();
      mem[0] = ins(JMP, 12'h005);
      mem[5] = ins(STA, 12'h020);
      mem[6] = ins(HALT, 12'h006);
      do_reset("t1");
      step(); outs("t1.exec_jmp",  12'h005, JMP, 1'b0, 1'b0, 1'b0);
      step(); outs("t1.fetch5",    12'h005, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t1.exec_sta",  12'h020, STA, 1'b1, 1'b0, 1'b0);
      step(); outs("t1.fetch6",    12'h006, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t1.exec_halt", 12'h006, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t1.halted",    12'h007, NOP, 1'b0, 1'b1, 1'b0);
      mem_ready = 1'b0;
      step(); outs("t1.halted_nr", 12'h007, NOP, 1'b0, 1'b1, 1'b0);
      mem_ready = 1'b1;
      step(); outs("t1.halted_r",  12'h007, NOP, 1'b0, 1'b1, 1'b0);

      // CALL/RET pair, then a second RET proves the stack was left empty.
      clear_mem();
      mem[0]      = ins(JMP, 12'h003);
      mem[3]      = ins(CALL, 12'h100);
      mem[12'h100] = ins(RET, 12'h000);
      mem[4]      = ins(RET, 12'h000);
      do_reset("t2");
      step(); outs("t2.exec_jmp",  12'h003, JMP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.fetch3",    12'h003, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.exec_call", 12'h100, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.fetch100",  12'h100, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.exec_ret",  12'h000, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.fetch4",    12'h004, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.exec_ret2", 12'h000, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t2.underflow", 12'h005, NOP, 1'b0, 1'b1, 1'b1);

      // Five nested CALLs: four succeed, the fifth overflows.
      clear_mem();
      mem[12'h000] = ins(CALL, 12'h010);
      mem[12'h010] = ins(CALL, 12'h020);
      mem[12'h020] = ins(CALL, 12'h030);
      mem[12'h030] = ins(CALL, 12'h040);
      mem[12'h040] = ins(CALL, 12'h050);
      do_reset("t3");
      step(); outs("t3.call1", 12'h010, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t3.f010",  12'h010, NOP, 1'b0, 1'b0, 1'b0);
      step(); step(); outs("t3.f020", 12'h020, NOP, 1'b0, 1'b0, 1'b0);
      step(); step(); outs("t3.f030", 12'h030, NOP, 1'b0, 1'b0, 1'b0);
      step(); step(); outs("t3.f040", 12'h040, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t3.call5",    12'h050, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t3.overflow", 12'h041, NOP, 1'b0, 1'b1, 1'b1);
      step(); outs("t3.frozen",   12'h041, NOP, 1'b0, 1'b1, 1'b1);

      // RET on an empty stack straight after reset.
      clear_mem();
      mem[0] = ins(RET, 12'h000);
      do_reset("t4");
      step(); outs("t4.exec_ret",  12'h000, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t4.underflow", 12'h001, NOP, 1'b0, 1'b1, 1'b1);

      // Wait states during STA execute, then reset while stalled.
      clear_mem();
      mem[0] = ins(STA, 12'h055);
      mem[1] = ins(STA, 12'h077);
      do_reset("t5");
      step(); outs("t5.exec_sta", 12'h055, STA, 1'b1, 1'b0, 1'b0);
      mem_ready = 1'b0;
      step(); outs("t5.wait1", 12'h055, STA, 1'b1, 1'b0, 1'b0);
      step(); outs("t5.wait2", 12'h055, STA, 1'b1, 1'b0, 1'b0);
      step(); outs("t5.wait3", 12'h055, STA, 1'b1, 1'b0, 1'b0);
      mem_ready = 1'b1;
      step(); outs("t5.fetch1", 12'h001, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t5.exec_sta2", 12'h077, STA, 1'b1, 1'b0, 1'b0);
      mem_ready = 1'b0;
      step(); outs("t5.stall", 12'h077, STA, 1'b1, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      outs("t5.async_reset", 12'h000, NOP, 1'b0, 1'b0, 1'b0);

      // PC wrap and conditional branches.
      clear_mem();
      mem[12'h000] = ins(JMP, 12'hFFE);
      mem[12'hFFE] = ins(JMPZ, 12'h200);
      mem[12'hFFF] = ins(JMPZ, 12'h200);
      mem[12'h200] = ins(JMPNZ, 12'h300);
      do_reset("t6");
      step(); outs("t6.exec_jmp", 12'hFFE, JMP, 1'b0, 1'b0, 1'b0);
      step(); outs("t6.fFFE",     12'hFFE, NOP, 1'b0, 1'b0, 1'b0);
      step(); outs("t6.jmpz_nt",  12'h200, JMPZ, 1'b0, 1'b0, 1'b0);
      step(); outs("t6.fFFF",     12'hFFF, NOP, 1'b0, 1'b0, 1'b0);
      step();
      step(); outs("t6.wrap",     12'h000, NOP, 1'b0, 1'b0, 1'b0);
      step();
      step(); outs("t6.fFFE_b",   12'hFFE, NOP, 1'b0, 1'b0, 1'b0);
      step();
      zflag = 1'b1;
      step(); outs("t6.jmpz_t",   12'h200, NOP, 1'b0, 1'b0, 1'b0);
      zflag = 1'b0;
      step(); outs("t6.exec_jnz", 12'h300, JMPNZ, 1'b0, 1'b0, 1'b0);
      step(); outs("t6.jnz_t",    12'h300, NOP, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
